fetch_req_tracker: RTL
======================

Name: fetch_req_tracker

Overview:
- Parametrised successor to the single-cycle fetch path. Replaces the fixed inst_sram_en/addr/rdata interface with a split-transaction sram-like handshake (req/addr_ok, then data_ok/rdata).
- Sits between the IF stage and the instruction memory/bridge.
- Tracks up to DEPTH outstanding fetches, returns responses in order, and buffers them until IF accepts.
- On flush (exception, ertn or branch redirect), discards every response belonging to pre-flush requests.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, response data width.
- DEPTH, 4, maximum in-flight plus buffered transactions; legal range 1..16.
- CNT_W (localparam), clog2(DEPTH+1), width of the counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- cpu_req_valid  input  1  IF presents a fetch address.
- cpu_req_addr  input  ADDR_W  fetch address.
- cpu_req_ready  output  1  request accepted this cycle; equals req & addr_ok.
- cpu_rsp_valid  output  1  buffered response available.
- cpu_rsp_data  output  DATA_W  response data at the FIFO head.
- cpu_rsp_ready  input  1  IF consumes the head response.
- flush  input  1  cancels all outstanding and buffered fetches.
- req  output  1  request to memory.
- addr  output  ADDR_W  equals cpu_req_addr.
- addr_ok  input  1  memory accepted the request.
- data_ok  input  1  memory returns a response, always in order.
- rdata  input  DATA_W  response data.
- outstanding  output  CNT_W  in-flight count plus FIFO count.
- proto_err  output  1  sticky error flag.

Behaviour:
- Reset:
  - Asynchronous reset while resetn=0 clears I, D, the FIFO pointers, FIFO count and proto_err.
  - While resetn=0, req=0, cpu_req_ready=0, cpu_rsp_valid=0 and outstanding=0. cpu_rsp_data holds its last value and is don't-care.
- State:
  - I: count of requests accepted by memory and not yet answered by data_ok.
  - D: count of discard-pending requests, with D<=I at all times.
  - FIFO of DEPTH entries, DATA_W wide, holding valid responses.
  - cap_ok = (I + fifo_cnt < DEPTH).
- Request issue (combinational):
  - req = cpu_req_valid & cap_ok & ~flush.
  - accept = req & addr_ok.
  - When cap_ok=0, req is held low even if cpu_req_valid is high. This is the backpressure path.
- Response path, no flush:
  - On data_ok with D>0: D decrements, rdata is dropped.
  - On data_ok with D=0: rdata is pushed into the FIFO.
  - I_next = I + accept - data_ok.
- Response path, flush=1 (takes priority):
  - No request is issued.
  - Any data_ok that cycle is dropped.
  - I_next = I - data_ok, D_next = I_next.
  - The FIFO is emptied and cpu_rsp_valid=0 from the next cycle.
  - A pop in the same cycle is a don't-care, because the FIFO is emptied.
- FIFO:
  - cpu_rsp_valid = fifo_cnt>0.
  - pop = cpu_rsp_valid & cpu_rsp_ready.
  - A push and a pop in the same cycle leave the count unchanged. With fifo_cnt=0, push and pop cannot coincide (cpu_rsp_valid=0, so pop is impossible); the pushed data appears the next cycle (no bypass; response latency data_ok to cpu_rsp_valid is 1 cycle).
  - Pointers wrap modulo DEPTH.
  - The FIFO never overflows, because cap_ok reserves a slot for every in-flight request.
- Protocol errors:
  - data_ok while I=0 sets proto_err, which stays set until reset.
  - That data_ok is otherwise ignored; the counters do not underflow.
- Consecutive flushes:
  - A flush while D>0 recomputes D = I_next.
  - Earlier discards are subsumed by this rule.
- Throughput: one accept and one data_ok per cycle are sustainable concurrently.

Test Plan:
- Single fetch: req high, addr_ok same cycle, data_ok 2 cycles later with rdata=0x02800000 -> cpu_rsp_valid next cycle with data 0x02800000; outstanding goes 1,1,1,0 after the pop.
- Backpressure (DEPTH=4):
  - Stimulus: 4 accepted requests, cpu_rsp_ready=0, 4 data_ok.
  - Response: the 5th request sees req=0 and cpu_req_ready=0.
  - After one pop, req=1 again. The FIFO outputs the data in issue order, 0x11,0x22,0x33,0x44.
- Flush with 3 in flight:
  - Stimulus: 3 requests outstanding (I=3), assert flush, then 3 data_ok arrive, then a new request issues and completes with 0xAA.
  - Response: the 3 responses are dropped, cpu_rsp_valid stays 0, and only 0xAA is delivered.
- Flush coincident with data_ok: I=2, FIFO holds 1 entry -> FIFO emptied, I=1, D=1; the next data_ok is dropped.
- Stray data_ok with I=0 -> proto_err=1 and stays 1; counters remain 0.
- Async reset mid-operation: resetn low with I=3 and the FIFO at 2 -> outputs go to 0 immediately, without waiting for a clk edge; after release, outstanding=0 and a fresh fetch completes normally.

Source files
------------

// File: rtl/fetch_req_tracker.sv
// Split-transaction fetch tracker: issues IF requests to memory, counts in-flight fetches,
// buffers in-order responses in a small FIFO and discards responses of pre-flush requests.
module fetch_req_tracker #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_req_valid,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_req_ready,
    output logic              cpu_rsp_valid,
    output logic [DATA_W-1:0] cpu_rsp_data,
    input  logic              cpu_rsp_ready,
    input  logic              flush,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  outstanding,
    output logic              proto_err
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   CAP      = (CNT_W + 1)'(DEPTH);

    logic [CNT_W-1:0]  in_flight, in_flight_nx;
    logic [CNT_W-1:0]  discard, discard_nx;
    logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_nx;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nx;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W:0]    total;
    logic              cap_ok;
    logic              accept;
    logic              stray;
    logic              rsp_evt;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A slot is reserved for every in-flight request, so the FIFO cannot overflow.
    assign total  = {1'b0, in_flight} + {1'b0, fifo_cnt};
    assign cap_ok = (total < CAP);

    assign req           = resetn & cpu_req_valid & cap_ok & ~flush;
    assign accept        = req & addr_ok;
    assign cpu_req_ready = accept;
    assign addr          = cpu_req_addr;

    assign cpu_rsp_valid = (fifo_cnt != '0);
    assign cpu_rsp_data  = mem[rd_ptr];
    assign outstanding   = total[CNT_W-1:0];

    // A response with nothing in flight is a protocol violation and is otherwise ignored.
    assign stray   = data_ok & (in_flight == '0);
    assign rsp_evt = data_ok & ~stray;
    assign push    = rsp_evt & ~flush & (discard == '0);
    assign pop     = cpu_rsp_valid & cpu_rsp_ready & ~flush;

    always_comb begin
        in_flight_nx = in_flight + CNT_W'(accept) - CNT_W'(rsp_evt);
        discard_nx   = discard;
        fifo_cnt_nx  = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_nx    = push ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_nx    = pop  ? ptr_inc(rd_ptr) : rd_ptr;
        if (flush) begin
            // Everything still in flight now belongs to the old stream.
            discard_nx  = in_flight_nx;
            fifo_cnt_nx = '0;
            wr_ptr_nx   = '0;
            rd_ptr_nx   = '0;
        end else if (rsp_evt && (discard != '0)) begin
            discard_nx = discard - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_flight <= '0;
            discard   <= '0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            proto_err <= 1'b0;
        end else begin
            in_flight <= in_flight_nx;
            discard   <= discard_nx;
            fifo_cnt  <= fifo_cnt_nx;
            wr_ptr    <= wr_ptr_nx;
            rd_ptr    <= rd_ptr_nx;
            if (stray) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rdata;
        end
    end

endmodule
